key_index_sequencer: RTL and testbench
======================================

KEY_INDEX_SEQUENCER -- requirements
Module: key_index_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 Port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port ce, input, 1 bit: clock enable; when 0, all state and outputs SHALL hold.
REQ-005 Port start, input, 1 bit: begin one block sequence; sampled only in IDLE with ce=1.
REQ-006 Port decrypt, input, 1 bit: direction select, latched when start is accepted (0=encrypt, 1=decrypt).
REQ-007 Port k_ready, input, 1 bit: key-word consumer accepts the current index.
REQ-008 Port k_valid, output, 1 bit: k_idx is valid.
REQ-009 Port k_idx, output, 6 bits: even index of the expanded-key word pair (K[k_idx], K[k_idx+1]).
REQ-010 Port phase, output, 2 bits: 00=input whitening, 01=round, 10=output whitening, 11=idle/done.
REQ-011 Port round, output, 4 bits: current round number, 0..15, valid when phase=01.
REQ-012 Port busy, output, 1 bit: high from start acceptance until the done cycle inclusive.
REQ-013 Port done, output, 1 bit: single-cycle pulse marking sequence completion.

Function
REQ-014 FSM states SHALL be IDLE, IN_WHT, ROUND, OUT_WHT and DONE.
REQ-015 A transfer SHALL occur on a rising edge where ce=1, k_valid=1 and k_ready=1.
REQ-016 k_valid SHALL be high in IN_WHT, ROUND and OUT_WHT, and low in IDLE and DONE.
REQ-017 k_idx SHALL be held stable while k_valid=1 and k_ready=0.
REQ-018 When IDLE and start=1 and ce=1, the FSM SHALL enter IN_WHT on the next edge, latch decrypt, set busy=1 and clear the sub-step counter.
REQ-019 In IN_WHT, after 2 transfers the FSM SHALL enter ROUND with round=0.
REQ-020 In ROUND, each transfer SHALL advance round; the transfer at round=15 SHALL move the FSM to OUT_WHT.
REQ-021 In OUT_WHT, after 2 transfers the FSM SHALL enter DONE.
REQ-022 In DONE, the FSM SHALL assert done=1 for exactly one ce-enabled cycle and then return to IDLE, with busy=0 in IDLE.
REQ-023 With encrypt latched, the k_idx sequence SHALL be 0, 2 (IN_WHT); 8+2r for r=0..15 (ROUND, 8..38 ascending); 4, 6 (OUT_WHT).
REQ-024 With decrypt latched, the k_idx sequence SHALL be 4, 6 (IN_WHT); 38-2r for r=0..15 (ROUND, 38..8 descending); 0, 2 (OUT_WHT).
REQ-025 k_idx SHALL be computed as 6-bit unsigned values and SHALL never exceed 38.
REQ-026 The round output SHALL always count upward 0..15, independent of direction.
REQ-027 A full sequence SHALL consist of exactly 20 transfers.
REQ-028 With k_ready held at 1 and ce at 1, done SHALL occur 21 cycles after the start acceptance edge.
REQ-029 start SHALL be ignored while busy=1, and decrypt changes mid-sequence SHALL have no effect.
REQ-030 If start=1 in the DONE cycle, it SHALL be ignored; a new start is accepted only from IDLE.
REQ-031 ce=0 SHALL freeze the FSM, counters and the done pulse, so that no transfer occurs even if k_ready=1.

Reset
REQ-032 On rst=1, at any time including mid-sequence, the block SHALL immediately force IDLE, k_valid=0, k_idx=0, phase=11, round=0, busy=0, done=0 and latched decrypt=0.
REQ-033 After rst deasserts, the block SHALL wait for a fresh start.

Verification
REQ-034 Encrypt, k_ready=1, ce=1: start pulse -> k_idx 0,2,8,10,...,38,4,6 on consecutive cycles, then done=1 for one cycle, busy low after.
REQ-035 Decrypt, k_ready=1: start with decrypt=1 -> k_idx 4,6,38,36,...,8,0,2, round 0..15 ascending, then done pulse.
REQ-036 Backpressure: k_ready=0 for 3 cycles at round=5 (encrypt) -> k_idx holds 18 and round holds 5; sequence resumes with no index skipped or repeated.
REQ-037 ce toggling 1/0 every cycle with k_ready=1 -> same 20-index sequence; done occurs at 42 cycles instead of 21.
REQ-038 rst pulse at round=9 (decrypt) -> outputs immediately reset per REQ-032; a later encrypt start yields a clean sequence starting at k_idx 0.
REQ-039 start held high through an entire sequence and through the DONE cycle -> second sequence begins only on the edge after IDLE is re-entered; no overlap.

Source files
------------

// File: rtl/key_index_sequencer.sv
// ---------------------------------------------------------------------------
// key_index_sequencer
//
// Walks the expanded-key word pairs for one cipher block: two input-whitening
// pairs, sixteen round pairs, two output-whitening pairs. Each step offers an
// even index k_idx naming the pair (K[k_idx], K[k_idx+1]) to a key-word
// consumer.
//
// Handshake: k_valid/k_ready. A transfer happens on a rising clk edge where
// ce=1, k_valid=1 and k_ready=1. While k_valid=1 and no transfer occurs, k_idx
// (and phase/round) stay unchanged. k_valid never drops without a transfer,
// except on reset.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   ce       in   clock enable; 0 freezes all state and outputs
//   start    in   begin a sequence (honoured only in IDLE with ce=1)
//   decrypt  in   direction, latched at start acceptance (0=enc, 1=dec)
//   k_ready  in   consumer accepts the current index
//   k_valid  out  k_idx is valid
//   k_idx    out  even key-word-pair index, 0..38
//   phase    out  00 in-whitening, 01 round, 10 out-whitening, 11 idle/done
//   round    out  round number 0..15 (meaningful in phase 01)
//   busy     out  high from start acceptance through the done cycle
//   done     out  one ce-enabled cycle pulse at sequence completion
// ---------------------------------------------------------------------------
module key_index_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       start,
    input  logic       decrypt,
    input  logic       k_ready,
    output logic       k_valid,
    output logic [5:0] k_idx,
    output logic [1:0] phase,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IN_WHT  = 3'd1,
        S_ROUND   = 3'd2,
        S_OUT_WHT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       sub_q,   sub_d;    // which of the two whitening pairs
    logic [3:0] round_q, round_d;
    logic       dec_q,   dec_d;    // direction latched at start

    logic       xfer;
    logic [5:0] sub2;              // 2*sub, zero-extended
    logic [5:0] round2;            // 2*round, zero-extended (0..30)

    // -----------------------------------------------------------------------
    // State registers. ce gates every update so ce=0 freezes the whole block,
    // including the done pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sub_q   <= 1'b0;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            sub_q   <= sub_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    assign xfer = ce & k_valid & k_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        round_d = round_q;
        dec_d   = dec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_IN_WHT;
                    dec_d   = decrypt;
                    sub_d   = 1'b0;
                    round_d = 4'd0;
                end
            end
            S_IN_WHT: begin
                if (xfer) begin
                    if (sub_q) begin
                        state_d = S_ROUND;
                        sub_d   = 1'b0;
                        round_d = 4'd0;
                    end else begin
                        sub_d = 1'b1;
                    end
                end
            end
            S_ROUND: begin
                if (xfer) begin
                    if (round_q == 4'd15) begin
                        state_d = S_OUT_WHT;
                        round_d = 4'd0;
                        sub_d   = 1'b0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            S_OUT_WHT: begin
                if (xfer) begin
                    if (sub_q) begin
                        state_d = S_DONE;
                        sub_d   = 1'b0;
                    end else begin
                        sub_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here; a new sequence
                // can only be accepted once IDLE has been re-entered.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sub_d   = 1'b0;
                round_d = 4'd0;
                dec_d   = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. Everything is decoded from registered state only, so k_idx is
    // inherently stable across stalled cycles.
    // Encrypt: 0,2 | 8+2r | 4,6     Decrypt: 4,6 | 38-2r | 0,2
    // -----------------------------------------------------------------------
    assign sub2   = {4'd0, sub_q, 1'b0};
    assign round2 = {1'b0, round_q, 1'b0};

    always_comb begin
        k_valid = 1'b0;
        k_idx   = 6'd0;
        phase   = 2'b11;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_IN_WHT: begin
                k_valid = 1'b1;
                phase   = 2'b00;
                k_idx   = dec_q ? (6'd4 + sub2) : sub2;
            end
            S_ROUND: begin
                k_valid = 1'b1;
                phase   = 2'b01;
                k_idx   = dec_q ? (6'd38 - round2) : (6'd8 + round2);
            end
            S_OUT_WHT: begin
                k_valid = 1'b1;
                phase   = 2'b10;
                k_idx   = dec_q ? sub2 : (6'd4 + sub2);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign round = round_q;

endmodule

// File: tb/tb_key_index_sequencer.sv
// ---------------------------------------------------------------------------
// tb_key_index_sequencer
//
// Directed bench for key_index_sequencer. A negedge monitor pops the expected
// {phase, round, k_idx} of every transfer from exp_q and records when the done
// cycle completes; the main sequence drives encrypt, decrypt, backpressure,
// ce toggling, mid-sequence reset and held-start scenarios.
// ---------------------------------------------------------------------------
module tb_key_index_sequencer;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       start;
    logic       decrypt;
    logic       k_ready;
    logic       k_valid;
    logic [5:0] k_idx;
    logic [1:0] phase;
    logic [3:0] round;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_at  = 0;
    int done_cnt = 0;

    logic [11:0] exp_q[$];

    key_index_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .start   (start),
        .decrypt (decrypt),
        .k_ready (k_ready),
        .k_valid (k_valid),
        .k_idx   (k_idx),
        .phase   (phase),
        .round   (round),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Sampled at negedge: inputs were set just after the previous posedge, so
    // this shows exactly what the coming edge will see.
    always @(negedge clk) begin
        if (ce && k_valid && k_ready) begin
            if (exp_q.size() == 0)
                check_eq("extra_xfer", {20'd0, phase, round, k_idx}, 32'hFFF);
            else
                check_eq("xfer", {20'd0, phase, round, k_idx}, {20'd0, exp_q.pop_front()});
        end
        if (done && ce) begin
            done_cnt++;
            done_at = cyc + 1;   // edge that closes the done cycle
        end
    end

    // Expected sequence for one block, straight from the key schedule layout.
    task automatic load_expected(input logic dec);
        logic [5:0] idx;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i < 2) begin
                idx = dec ? 6'(4 + 2 * i) : 6'(2 * i);
                exp_q.push_back({2'b00, 4'd0, idx});
            end else if (i < 18) begin
                idx = dec ? 6'(38 - 2 * (i - 2)) : 6'(8 + 2 * (i - 2));
                exp_q.push_back({2'b01, 4'(i - 2), idx});
            end else begin
                idx = dec ? 6'(2 * (i - 18)) : 6'(4 + 2 * (i - 18));
                exp_q.push_back({2'b10, 4'd0, idx});
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called #1 after a posedge. ce_mode 1 = ce toggling after acceptance.
    // stall_round >= 0: hold k_ready low 3 cycles at that round.
    // rst_round >= 0: pulse reset when that round is presented.
    task automatic run_seq(input logic dec, input int ce_mode, input int stall_round,
                           input int rst_round, input logic hold, output int lat);
        int acc;
        int stalls;
        bit fin;
        load_expected(dec);
        done_at  = 0;
        done_cnt = 0;
        stalls   = 0;
        fin      = 0;
        lat      = -1;
        ce       = 1'b1;
        k_ready  = 1'b1;
        decrypt  = dec;
        start    = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        check_eq("accept_busy", {31'd0, busy}, 32'd1);
        start = hold;
        for (int k = 1; k <= 200 && !fin; k++) begin
            if (rst_round >= 0 && phase == 2'b01 && round == 4'(rst_round)) begin
                rst = 1'b1;
                #1;
                check_eq("rst_k_valid", {31'd0, k_valid}, 32'd0);
                check_eq("rst_k_idx", {26'd0, k_idx}, 32'd0);
                check_eq("rst_phase", {30'd0, phase}, 32'd3);
                check_eq("rst_round", {28'd0, round}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_done", {31'd0, done}, 32'd0);
                #1;
                rst = 1'b0;
                start = 1'b0;
                exp_q.delete();
                return;
            end
            ce = (ce_mode == 1) ? ((k % 2) == 0) : 1'b1;
            k_ready = 1'b1;
            if (stall_round >= 0 && phase == 2'b01 && round == 4'(stall_round) && stalls < 3) begin
                k_ready = 1'b0;
                stalls++;
                check_eq("stall_idx", {26'd0, k_idx}, 32'(8 + 2 * stall_round));
            end
            decrypt = 1'($urandom_range(0, 1));
            if (!hold) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (stalls > 0 && stalls <= 3 && !k_ready)
                check_eq("stall_round", {28'd0, round}, 32'(stall_round));
            if (done_at != 0 && !busy) fin = 1;
        end
        if (!fin) check_eq("timeout", 32'd0, 32'd1);
        if (!hold) start = 1'b0;
        ce      = 1'b1;
        k_ready = 1'b1;
        lat = done_at - acc;
        check_eq("xfer_count_left", 32'(exp_q.size()), 32'd0);
        check_eq("done_width", 32'(done_cnt), 32'd1);
        check_eq("end_phase", {30'd0, phase}, 32'd3);
        check_eq("end_k_valid", {31'd0, k_valid}, 32'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        int lat;
        rst     = 1'b1;
        ce      = 1'b0;
        start   = 1'b0;
        decrypt = 1'b0;
        k_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_k_valid", {31'd0, k_valid}, 32'd0);
        check_eq("reset_k_idx", {26'd0, k_idx}, 32'd0);
        check_eq("reset_phase", {30'd0, phase}, 32'd3);
        check_eq("reset_round", {28'd0, round}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        ce = 1'b1;
        k_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_after_reset", {30'd0, phase}, 32'd3);

        // encrypt, free-running
        run_seq(1'b0, 0, -1, -1, 1'b0, lat);
        check_eq("enc_latency", 32'(lat), 32'd21);

        // decrypt, free-running
        run_seq(1'b1, 0, -1, -1, 1'b0, lat);
        check_eq("dec_latency", 32'(lat), 32'd21);

        // encrypt, 3-cycle stall at round 5 (k_idx 18)
        run_seq(1'b0, 0, 5, -1, 1'b0, lat);
        check_eq("stall_latency", 32'(lat), 32'd24);

        // encrypt, ce toggling every cycle
        run_seq(1'b0, 1, -1, -1, 1'b0, lat);
        check_eq("ce_toggle_latency", 32'(lat), 32'd42);

        // decrypt, reset at round 9, then a clean encrypt
        run_seq(1'b1, 0, -1, 9, 1'b0, lat);
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_idle_phase", {30'd0, phase}, 32'd3);
        check_eq("post_rst_idle_valid", {31'd0, k_valid}, 32'd0);
        run_seq(1'b0, 0, -1, -1, 1'b0, lat);
        check_eq("post_rst_latency", 32'(lat), 32'd21);

        // start held high throughout: second run only after IDLE re-entered
        run_seq(1'b0, 0, -1, -1, 1'b1, lat);
        check_eq("hold_latency", 32'(lat), 32'd21);
        check_eq("hold_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check_eq("hold_restart_busy", {31'd0, busy}, 32'd1);
        check_eq("hold_restart_phase", {30'd0, phase}, 32'd0);
        check_eq("hold_restart_idx", {26'd0, k_idx}, 32'd0);
        rst = 1'b1;
        start = 1'b0;
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_eq("final_idle", {30'd0, phase}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
